// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: binary value -> BCD (double-dabble) -> tear-free display register -> multiplexed 7-seg scan.
// Latency: load sampled in cycle 0, busy in cycles 1..BIN_W+1, new digits in the display register from cycle BIN_W+2.
// Backpressure: load is ignored while busy; scan free-runs. Optional dimming input bright[3:0] under macro SEVSEG_DIM_EN.
module sevenseg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int CLK_HZ      = 100000000,
  parameter int SCAN_HZ     = 1000,
  parameter int SEG_ACT_LOW = 1,
  parameter int CS_ACT_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp,
`ifdef SEVSEG_DIM_EN
  input  logic [3:0]        bright,
`endif
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic              seg_dp,
  output logic [DIGITS-1:0] cs
);

  // Largest power of ten below 2^64 is 10^19; DIGITS is limited to 8 so this never saturates.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam int          BCD_W        = 4 * DIGITS;
  localparam int          DIV_RAW      = CLK_HZ / SCAN_HZ;
  localparam int          DIV          = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int          PRE_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          CNT_W        = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_DISP     = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] MAX_BIN      = (64'd1 << BIN_W) - 64'd1;
  // When every representable input fits on the display, overflow can never be raised.
  localparam bit          OVF_POSSIBLE = (MAX_BIN > MAX_DISP);

  // Internal digit codes: 0-9 are decimal digits, the rest are symbols.
  localparam logic [3:0]  CODE_BLANK   = 4'hF;
  localparam logic [3:0]  CODE_DASH    = 4'hE;

  // Output "off" levels; XOR with an active-high pattern applies the pin polarity.
  localparam logic [6:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] CS_OFF  = (CS_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Active-high glyph table, bit 6 = A .. bit 0 = G.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:      s = 7'b1111110;
      4'd1:      s = 7'b0110000;
      4'd2:      s = 7'b1101101;
      4'd3:      s = 7'b1111001;
      4'd4:      s = 7'b0110011;
      4'd5:      s = 7'b1011011;
      4'd6:      s = 7'b1011111;
      4'd7:      s = 7'b1110000;
      4'd8:      s = 7'b1111111;
      4'd9:      s = 7'b1111011;
      CODE_DASH: s = 7'b0000001;
      default:   s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Conversion engine state
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   sr_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_d;
  logic               lz_q;
  logic               ovf_cap_q;
  logic               busy_q;
  logic               overflow_q;
  logic [3:0]         disp_q      [DIGITS];
  logic [3:0]         commit_code [DIGITS];
  logic [63:0]        value_ext;
  logic               ovf_now;

  // Scan state
  logic [PRE_W-1:0]   pre_q;
  logic [IDX_W-1:0]   idx_q;
  logic               tick;
  logic               dim_on;
  logic [3:0]         cur_code;
  logic [DIGITS-1:0]  sel_onehot;

  // Registered pin drivers
  logic [6:0]         seg_q;
  logic               seg_dp_q;
  logic [DIGITS-1:0]  cs_q;

  assign value_ext = 64'(value);
  assign ovf_now   = OVF_POSSIBLE && (value_ext > MAX_DISP);

  // One double-dabble step: correct every nibble >= 5, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1]};
  end

  // Build the committed digit codes: dashes on overflow, otherwise BCD with optional leading-zero blanking.
  always_comb begin
    logic       hi_zero;
    logic [3:0] nib;
    hi_zero = lz_q;
    nib     = 4'd0;
    for (int i = 0; i < DIGITS; i++) commit_code[i] = CODE_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      if (ovf_cap_q)                         commit_code[i] = CODE_DASH;
      else if (hi_zero && nib == 4'd0 && i != 0) commit_code[i] = CODE_BLANK;
      else                                   commit_code[i] = nib;
      if (nib != 4'd0) hi_zero = 1'b0;
    end
  end

  // Conversion FSM: capture on load, BIN_W shift iterations, then one atomic display commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      bcd_q      <= '0;
      lz_q       <= 1'b0;
      ovf_cap_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= CODE_BLANK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            sr_q      <= value;
            bcd_q     <= '0;
            lz_q      <= blank_lz;
            ovf_cap_q <= ovf_now;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_d;
          sr_q  <= sr_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          for (int i = 0; i < DIGITS; i++) disp_q[i] <= commit_code[i];
          overflow_q <= ovf_cap_q;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tick = (pre_q == PRE_W'(DIV - 1));

  // Prescaler wraps every DIV cycles; the digit index advances on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEVSEG_DIM_EN
  localparam int DIM_W = PRE_W + 5;
  logic [DIM_W-1:0] dim_lim;
  // Digit select is only allowed during the first ((bright+1)*DIV)/16 prescaler counts.
  always_comb begin
    dim_lim = ((DIM_W'(bright) + DIM_W'(1)) * DIM_W'(DIV)) >> 4;
    dim_on  = (DIM_W'(pre_q) < dim_lim);
  end
`else
  assign dim_on = 1'b1;
`endif

  assign cur_code   = disp_q[idx_q];
  assign sel_onehot = DIGITS'(1) << idx_q;

  // Pin registers trail the index by one cycle; the cycle after a tick drives no digit to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= SEG_OFF;
      seg_dp_q <= DP_OFF;
      cs_q     <= CS_OFF;
    end else begin
      seg_q    <= decode(cur_code) ^ SEG_OFF;
      seg_dp_q <= ((cur_code != CODE_BLANK) && dp[idx_q]) ^ DP_OFF;
      cs_q     <= (!tick && dim_on) ? (sel_onehot ^ CS_OFF) : CS_OFF;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign seg_dp   = seg_dp_q;
  assign cs       = cs_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: DIGITS=4, BIN_W=14, DIV=16, active-low pins.
// Reference model computes digits from decimal arithmetic on the loaded value.
// Define SEVSEG_DIM_EN for both files to also exercise the brightness input.
module tb_sevenseg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int C_BLANK = 10;
  localparam int C_DASH  = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BIN_W-1:0]  value;
  logic              load;
  logic              blank_lz;
  logic [DIGITS-1:0] dp;
  logic              busy;
  logic              overflow;
  logic [6:0]        seg;
  logic              seg_dp;
  logic [DIGITS-1:0] cs;
`ifdef SEVSEG_DIM_EN
  logic [3:0]        bright;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   exp_code [DIGITS];
  logic exp_ovf;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .CLK_HZ(1600), .SCAN_HZ(100),
    .SEG_ACT_LOW(1), .CS_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz), .dp(dp),
`ifdef SEVSEG_DIM_EN
    .bright(bright),
`endif
    .busy(busy), .overflow(overflow), .seg(seg), .seg_dp(seg_dp), .cs(cs)
  );

  // Expected per-digit content from decimal arithmetic on the loaded value.
  task automatic model_load(input int v, input bit lz);
    int p;
    exp_ovf = (v > 9999);
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (exp_ovf)                  exp_code[i] = C_DASH;
      else if (lz && i > 0 && v < p) exp_code[i] = C_BLANK;
      else                          exp_code[i] = (v / p) % 10;
      p = p * 10;
    end
  endtask

  task automatic model_blank();
    exp_ovf = 1'b0;
    for (int i = 0; i < DIGITS; i++) exp_code[i] = C_BLANK;
  endtask

  // Active-low pin pattern for a glyph (A..G = bit6..bit0).
  function automatic logic [6:0] exp_seg(input int c);
    logic [6:0] a;
    case (c)
      0: a = 7'b1111110;  1: a = 7'b0110000;  2: a = 7'b1101101;  3: a = 7'b1111001;
      4: a = 7'b0110011;  5: a = 7'b1011011;  6: a = 7'b1011111;  7: a = 7'b1110000;
      8: a = 7'b1111111;  9: a = 7'b1111011;  C_DASH: a = 7'b0000001;
      default: a = 7'b0000000;
    endcase
    return ~a;
  endfunction

  // Watch a full scan and compare each digit's segments and dp the first time it is selected.
  task automatic check_display(input string tag);
    bit                seen [DIGITS];
    logic [DIGITS-1:0] sel;
    logic              expdp;
    for (int i = 0; i < DIGITS; i++) seen[i] = 1'b0;
    for (int c = 0; c < DIGITS * 16 + 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < DIGITS; k++) begin
        sel = ~(DIGITS'(1) << k);
        if (cs == sel && !seen[k]) begin
          seen[k] = 1'b1;
          checks++;
          if (seg !== exp_seg(exp_code[k])) begin
            failures++;
            $display("FAIL %s seg digit%0d: got %b want %b", tag, k, seg, exp_seg(exp_code[k]));
          end
          expdp = (exp_code[k] == C_BLANK) ? 1'b1 : ~dp[k];
          checks++;
          if (seg_dp !== expdp) begin
            failures++;
            $display("FAIL %s seg_dp digit%0d: got %b want %b", tag, k, seg_dp, expdp);
          end
        end
      end
    end
    for (int k = 0; k < DIGITS; k++) begin
      checks++;
      if (!seen[k]) begin
        failures++;
        $display("FAIL %s select digit%0d: got never want selected", tag, k);
      end
    end
  endtask

  // Pulse load for one cycle, then count busy cycles (bounded).
  task automatic do_load(input int v, input bit lz, output int busy_cycles);
    @(negedge clk);
    value = BIN_W'(v); blank_lz = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic load_and_check(input string tag, input int v, input bit lz);
    int bc;
    do_load(v, lz, bc);
    checks++;
    if (bc != BIN_W + 1) begin
      failures++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, bc, BIN_W + 1);
    end
    model_load(v, lz);
    checks++;
    if (overflow !== exp_ovf) begin
      failures++;
      $display("FAIL %s overflow: got %b want %b", tag, overflow, exp_ovf);
    end
    check_display(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 4'b1111)     begin failures++; $display("FAIL rst_cs: got %b want 1111", cs); end
    checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL rst_seg: got %b want 1111111", seg); end
    checks++; if (seg_dp !== 1'b1)    begin failures++; $display("FAIL rst_dp: got %b want 1", seg_dp); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    rst_n = 1'b1;
    model_blank();
    dp = 4'b1111;
    check_display("rst_blank");
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_convert();
    dp = 4'b0100;
    load_and_check("conv1234", 1234, 1'b0);
  endtask

  task automatic test_lz();
    dp = 4'b1111;
    load_and_check("lz7", 7, 1'b1);
    load_and_check("lz0", 0, 1'b1);
    load_and_check("lz100", 100, 1'b1);
  endtask

  task automatic test_overflow();
    dp = 4'b0000;
    load_and_check("ovf12000", 12000, 1'b0);
    load_and_check("ovf9999", 9999, 1'b0);
  endtask

  task automatic test_back_to_back();
    int bc;
    dp = 4'b0001;
    @(negedge clk);
    value = BIN_W'(1111); blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    value = BIN_W'(2222);
    @(negedge clk);
    load = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin bc++; @(negedge clk); end
    checks++;
    if (bc != BIN_W) begin
      failures++;
      $display("FAIL b2b_busy_len: got %0d want %0d", bc, BIN_W);
    end
    model_load(1111, 1'b0);
    check_display("b2b_ignore");
    // A load presented in the first non-busy cycle must be accepted.
    do_load(3333, 1'b0, bc);
    value = BIN_W'(4444); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept_busy: got %b want 1", busy);
    end
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin bc++; @(negedge clk); end
    model_load(4444, 1'b0);
    check_display("b2b_accept");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    value = BIN_W'(8765); blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (BIN_W + 5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy_late: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL abort_ovf: got %b want 0", overflow); end
    model_blank();
    check_display("abort_blank");
  endtask

  task automatic test_scan_timing();
    int act [64];
    int cnt [DIGITS];
    int blanks = 0, invalid = 0, last_blank = -1;
    logic [DIGITS-1:0] sel;
    for (int k = 0; k < DIGITS; k++) cnt[k] = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      act[c] = -2;
      if (cs == 4'b1111) act[c] = -1;
      for (int k = 0; k < DIGITS; k++) begin
        sel = ~(DIGITS'(1) << k);
        if (cs == sel) act[c] = k;
      end
    end
    for (int c = 0; c < 64; c++) begin
      if (act[c] == -1) begin
        blanks++;
        if (last_blank >= 0) begin
          checks++;
          if (c - last_blank != 16) begin
            failures++;
            $display("FAIL scan_blank_gap: got %0d want 16", c - last_blank);
          end
        end
        last_blank = c;
      end else if (act[c] == -2) invalid++;
      else cnt[act[c]]++;
      if (c > 0 && c < 63 && act[c] == -1 && act[c-1] >= 0 && act[c+1] >= 0) begin
        checks++;
        if (act[c+1] != (act[c-1] + 1) % DIGITS) begin
          failures++;
          $display("FAIL scan_rotate: got digit%0d want digit%0d", act[c+1], (act[c-1] + 1) % DIGITS);
        end
      end
    end
    checks++; if (blanks != 4) begin failures++; $display("FAIL scan_blanks: got %0d want 4", blanks); end
    checks++; if (invalid != 0) begin failures++; $display("FAIL scan_invalid_cs: got %0d want 0", invalid); end
    for (int k = 0; k < DIGITS; k++) begin
      checks++;
      if (cnt[k] != 15) begin
        failures++;
        $display("FAIL scan_duty digit%0d: got %0d want 15", k, cnt[k]);
      end
    end
  endtask

`ifdef SEVSEG_DIM_EN
  task automatic test_dim();
    int b, active, want;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 3 : $urandom_range(0, 15);
      @(negedge clk);
      bright = 4'(b);
      repeat (2) @(negedge clk);
      active = 0;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (cs != 4'b1111) active++;
      end
      want = 4 * (((b + 1) > 15) ? 15 : (b + 1));
      checks++;
      if (active != want) begin
        failures++;
        $display("FAIL dim_bright%0d: got %0d want %0d", b, active, want);
      end
    end
    bright = 4'd15;
  endtask
`endif

  task automatic test_random();
    int v;
    bit lz;
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(10000, 16383);
      endcase
      lz = 1'($urandom_range(0, 1));
      dp = 4'($urandom_range(0, 15));
      load_and_check($sformatf("rand%0d_v%0d", n, v), v, lz);
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0; dp = '0;
`ifdef SEVSEG_DIM_EN
    bright = 4'd15;
`endif
    test_reset();
    test_convert();
    test_lz();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_scan_timing();
`ifdef SEVSEG_DIM_EN
    test_dim();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
